// File: rtl/spdif_frame_sequencer.sv
// spdif_frame_sequencer
//   Feeds the S/PDIF sub-frame encoder. Takes one stereo pair per input
//   handshake and emits two sub-frames (left, then right) per pair. It tracks
//   the position inside the 192-frame channel-status block, flags block start
//   on frame 0 left, and serialises a 32-bit consumer channel-status word, one
//   bit per frame, onto the control bit.
//
// Ports
//   clk128            128 x fs clock
//   reset             asynchronous, active-high
//   i_valid/i_ready   stereo pair handshake (i_ready is combinational)
//   i_left/i_right    WIDTH-bit two's complement samples
//   i_cs_word         channel-status bits 0..31, latched at each block start
//   o_valid/o_ready   sub-frame handshake towards the encoder
//   o_is_frame_start  high only on frame 0 left (B preamble)
//   o_is_left         1 = left sub-frame, 0 = right sub-frame
//   o_audio           sample MSB-aligned into 24 bits, LSBs zero
//   o_user            user bit, always 0
//   o_control         channel-status bit of the current frame
//   o_frame_index     frame number within the block, 0..191
module spdif_frame_sequencer #(
  parameter int WIDTH = 24
) (
  input  logic             clk128,
  input  logic             reset,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [WIDTH-1:0] i_left,
  input  logic [WIDTH-1:0] i_right,
  input  logic [31:0]      i_cs_word,
  output logic             o_valid,
  input  logic             o_ready,
  output logic             o_is_frame_start,
  output logic             o_is_left,
  output logic [23:0]      o_audio,
  output logic             o_user,
  output logic             o_control,
  output logic [7:0]       o_frame_index
);

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

  state_t                   state;
  logic [7:0]               frame_cnt;
  logic [31:0]              cs_reg;
  logic signed [WIDTH-1:0]  r_hold;

  logic [7:0]               frame_nxt;
  logic [7:0]               cap_idx;
  logic                     cap_ctl;
  logic                     take;

  // MSB alignment keeps the sign in bit 23; the low bits are zero padding,
  // never sign extension.
  function automatic logic [23:0] align(input logic signed [WIDTH-1:0] s);
    logic [23:0] a;
    a = '0;
    a[23 -: WIDTH] = s;
    return a;
  endfunction

  always_comb begin
    i_ready = 1'b0;
    case (state)
      IDLE:    i_ready = 1'b1;
      LEFT:    i_ready = 1'b0;
      RIGHT:   i_ready = o_ready;
      default: i_ready = 1'b0;
    endcase
  end

  assign take      = i_valid && i_ready;
  assign frame_nxt = (frame_cnt == 8'd191) ? 8'd0 : frame_cnt + 8'd1;
  // A capture from RIGHT happens on the same edge that retires the current
  // frame, so the new pair belongs to the following frame.
  assign cap_idx   = (state == RIGHT) ? frame_nxt : frame_cnt;
  assign cap_ctl   = (cap_idx == 8'd0)  ? i_cs_word[0] :
                     (cap_idx < 8'd32)  ? cs_reg[cap_idx[4:0]] : 1'b0;

  // Right sample waits here while the left sub-frame is on the output.
  always_ff @(posedge clk128) begin
    if (take) r_hold <= i_right;
  end

  // Stage boundary: sequencer state and registered sub-frame outputs.
  always_ff @(posedge clk128 or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      frame_cnt        <= 8'd0;
      cs_reg           <= 32'd0;
      o_valid          <= 1'b0;
      o_is_frame_start <= 1'b0;
      o_is_left        <= 1'b0;
      o_audio          <= 24'd0;
      o_user           <= 1'b0;
      o_control        <= 1'b0;
      o_frame_index    <= 8'd0;
    end else begin
      o_user <= 1'b0;
      case (state)
        IDLE: ;
        LEFT: begin
          if (o_ready) begin
            o_audio          <= align(r_hold);
            o_is_left        <= 1'b0;
            o_is_frame_start <= 1'b0;
            state            <= RIGHT;
          end
        end
        RIGHT: begin
          if (o_ready) begin
            frame_cnt <= frame_nxt;
            o_valid   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // A capture overrides the drain-to-IDLE above, giving back-to-back
      // pairs without a bubble.
      if (take) begin
        o_valid          <= 1'b1;
        o_is_left        <= 1'b1;
        o_audio          <= align(i_left);
        o_frame_index    <= cap_idx;
        o_is_frame_start <= (cap_idx == 8'd0);
        o_control        <= cap_ctl;
        if (cap_idx == 8'd0) cs_reg <= i_cs_word;
        state            <= LEFT;
      end
    end
  end

endmodule

// File: tb/tb_spdif_frame_sequencer.sv
module tb_spdif_frame_sequencer;

  logic        clk128 = 1'b0;
  logic        reset;
  logic        i_valid;
  logic [23:0] i_left, i_right;
  logic [15:0] i_left16, i_right16;
  logic [31:0] i_cs_word;
  logic        o_ready;

  logic        i_ready, o_valid, o_is_frame_start, o_is_left, o_user, o_control;
  logic [23:0] o_audio;
  logic [7:0]  o_frame_index;

  logic        i_ready16, o_valid16, o_fs16, o_left16, o_user16, o_control16;
  logic [23:0] o_audio16;
  logic [7:0]  o_index16;

  assign i_left16  = i_left[23:8];
  assign i_right16 = i_right[23:8];

  spdif_frame_sequencer #(.WIDTH(24)) dut (
    .clk128(clk128), .reset(reset), .i_valid(i_valid), .i_ready(i_ready),
    .i_left(i_left), .i_right(i_right), .i_cs_word(i_cs_word),
    .o_valid(o_valid), .o_ready(o_ready), .o_is_frame_start(o_is_frame_start),
    .o_is_left(o_is_left), .o_audio(o_audio), .o_user(o_user),
    .o_control(o_control), .o_frame_index(o_frame_index)
  );

  spdif_frame_sequencer #(.WIDTH(16)) dut16 (
    .clk128(clk128), .reset(reset), .i_valid(i_valid), .i_ready(i_ready16),
    .i_left(i_left16), .i_right(i_right16), .i_cs_word(i_cs_word),
    .o_valid(o_valid16), .o_ready(o_ready), .o_is_frame_start(o_fs16),
    .o_is_left(o_left16), .o_audio(o_audio16), .o_user(o_user16),
    .o_control(o_control16), .o_frame_index(o_index16)
  );

  always #5 clk128 = ~clk128;

  // {is_left, frame_start, index, control, user, audio24, audio16}
  logic [59:0] obs;
  assign obs = {o_is_left, o_is_frame_start, o_frame_index, o_control, o_user,
                o_audio, o_audio16};

  int checks = 0;
  int failures = 0;

  // Reference model: an ordered list of sub-frames still owed to the encoder
  // and a count of sub-frames already delivered since reset.
  typedef struct packed {
    logic [23:0] aud;
    logic [23:0] aud16;
    logic        left;
    logic [31:0] cs;
  } sub_t;
  sub_t        sq[$];
  int          n_sub = 0;
  logic [31:0] cs_lat = '0;

  task automatic tick();
    @(posedge clk128);
    #1;
  endtask

  // Samples mid-cycle, i.e. the values the next rising edge will see.
  task automatic monitor();
    sub_t        e;
    int          fr;
    logic        exp_rdy, exp_ctl;
    logic [59:0] exp_obs;
    forever begin
      @(negedge clk128);
      if (reset) begin
        sq.delete();
        n_sub  = 0;
        cs_lat = '0;
      end else begin
        exp_rdy = (sq.size() == 0) || (!sq[0].left && o_ready);
        checks++;
        if (i_ready !== exp_rdy || i_ready16 !== exp_rdy) begin
          failures++;
          $display("FAIL mon_i_ready t=%0t got=%b/%b exp=%b", $time, i_ready, i_ready16, exp_rdy);
        end
        checks++;
        if (o_valid !== (sq.size() != 0) || o_valid16 !== (sq.size() != 0)) begin
          failures++;
          $display("FAIL mon_o_valid t=%0t got=%b/%b exp=%b", $time, o_valid, o_valid16, sq.size() != 0);
        end
        if (sq.size() != 0) begin
          e  = sq[0];
          fr = (n_sub / 2) % 192;
          exp_ctl = (fr == 0) ? e.cs[0] : ((fr < 32) ? cs_lat[fr] : 1'b0);
          exp_obs = {e.left, e.left && (fr == 0), 8'(fr), exp_ctl, 1'b0, e.aud, e.aud16};
          checks++;
          if (obs !== exp_obs) begin
            failures++;
            $display("FAIL mon_subframe t=%0t got=%h exp=%h", $time, obs, exp_obs);
          end
          if (o_ready) begin
            if (e.left && fr == 0) cs_lat = e.cs;
            void'(sq.pop_front());
            n_sub++;
          end
        end
        if (i_valid && exp_rdy) begin
          e.aud = i_left;  e.aud16 = {i_left[23:8], 8'h00};  e.left = 1'b1; e.cs = i_cs_word;
          sq.push_back(e);
          e.aud = i_right; e.aud16 = {i_right[23:8], 8'h00}; e.left = 1'b0;
          sq.push_back(e);
        end
      end
    end
  endtask

  task automatic test_reset();
    i_valid = 1'b0; o_ready = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (obs !== 60'd0 || o_valid !== 1'b0 || i_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_values got obs=%h valid=%b rdy=%b exp obs=0 valid=0 rdy=1", obs, o_valid, i_ready);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_pair();
    o_ready = 1'b1; i_cs_word = 32'h0;
    i_left = 24'h123456; i_right = 24'hABCDEF; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    checks++;
    if ({o_valid, o_is_frame_start, o_is_left, o_audio, o_frame_index} !== {3'b111, 24'h123456, 8'd0}) begin
      failures++;
      $display("FAIL single_left got v=%b fs=%b l=%b a=%h i=%0d exp 1 1 1 123456 0",
               o_valid, o_is_frame_start, o_is_left, o_audio, o_frame_index);
    end
    tick();
    checks++;
    if ({o_valid, o_is_frame_start, o_is_left, o_audio} !== {3'b100, 24'hABCDEF}) begin
      failures++;
      $display("FAIL single_right got v=%b fs=%b l=%b a=%h exp 1 0 0 abcdef",
               o_valid, o_is_frame_start, o_is_left, o_audio);
    end
    tick();
    checks++;
    if (o_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_done got o_valid=%b exp 0", o_valid);
    end
  endtask

  task automatic test_cs_block();
    logic [31:0] word;
    int fr;
    word = 32'h0000_0005;
    reset = 1'b1; tick(); reset = 1'b0; tick();
    o_ready = 1'b1; i_cs_word = word; i_valid = 1'b1;
    i_left = $urandom; i_right = $urandom;
    for (int k = 0; k < 386; k++) begin
      tick();
      i_left = $urandom; i_right = $urandom;
      fr = (k / 2) % 192;
      if (k % 2 == 0) begin
        checks++;
        if ({o_valid, o_is_left, o_is_frame_start, o_frame_index, o_control} !==
            {2'b11, fr == 0, 8'(fr), (fr < 32) ? word[fr] : 1'b0}) begin
          failures++;
          $display("FAIL cs_block k=%0d got fs=%b idx=%0d ctl=%b exp fs=%b idx=%0d ctl=%b", k,
                   o_is_frame_start, o_frame_index, o_control, fr == 0, fr, (fr < 32) ? word[fr] : 1'b0);
        end
      end
    end
    i_valid = 1'b0;
    for (int c = 0; c < 8 && o_valid; c++) tick();
    checks++;
    if (o_valid !== 1'b0) begin
      failures++;
      $display("FAIL cs_block_drain got o_valid=%b exp 0", o_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [59:0] snap;
    o_ready = 1'b0; i_left = $urandom; i_right = $urandom; i_valid = 1'b1;
    tick();
    snap = obs;
    i_left = $urandom; i_right = $urandom;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (obs !== snap || o_valid !== 1'b1 || i_ready !== 1'b0) begin
        failures++;
        $display("FAIL backpressure c=%0d got obs=%h v=%b rdy=%b exp obs=%h v=1 rdy=0",
                 c, obs, o_valid, i_ready, snap);
      end
    end
    o_ready = 1'b1;
    tick(); tick();
    i_valid = 1'b0;
    for (int c = 0; c < 8 && o_valid; c++) tick();
    checks++;
    if (o_valid !== 1'b0 || sq.size() != 0) begin
      failures++;
      $display("FAIL backpressure_drain got v=%b pending=%0d exp 0 0", o_valid, sq.size());
    end
  endtask

  task automatic test_width16();
    o_ready = 1'b1; i_left = 24'h8001A5; i_right = 24'h7FFE3C; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    checks++;
    if (o_audio16 !== 24'h800100 || o_audio !== 24'h8001A5) begin
      failures++;
      $display("FAIL width16_left got a16=%h a24=%h exp 800100 8001a5", o_audio16, o_audio);
    end
    tick();
    checks++;
    if (o_audio16 !== 24'h7FFE00) begin
      failures++;
      $display("FAIL width16_right got a16=%h exp 7ffe00", o_audio16);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] csn;
    reset = 1'b1; tick(); reset = 1'b0; tick();
    o_ready = 1'b1; i_cs_word = 32'h0; i_valid = 1'b1;
    for (int k = 0; k < 76; k++) begin
      tick();
      i_left = $urandom; i_right = $urandom;
    end
    checks++;
    if (o_frame_index !== 8'd37 || o_is_left !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_pos got idx=%0d left=%b exp 37 0", o_frame_index, o_is_left);
    end
    reset = 1'b1; i_valid = 1'b0;
    #1;
    checks++;
    if (obs !== 60'd0 || o_valid !== 1'b0 || i_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_values got obs=%h v=%b rdy=%b exp 0 0 1", obs, o_valid, i_ready);
    end
    tick();
    reset = 1'b0;
    csn = $urandom; csn[1:0] = 2'b10;
    i_cs_word = csn; i_valid = 1'b1;
    tick();
    checks++;
    if ({o_valid, o_is_frame_start, o_is_left, o_frame_index, o_control} !== {3'b111, 8'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid_restart got fs=%b idx=%0d ctl=%b exp 1 0 0", o_is_frame_start, o_frame_index, o_control);
    end
    i_cs_word = 32'h0;
    tick(); tick();
    checks++;
    if (o_frame_index !== 8'd1 || o_control !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_relatch got idx=%0d ctl=%b exp 1 1", o_frame_index, o_control);
    end
    i_valid = 1'b0;
    for (int c = 0; c < 8 && o_valid; c++) tick();
  endtask

  task automatic test_cs_change();
    logic [31:0] wa, wb, w;
    int fr;
    reset = 1'b1; tick(); reset = 1'b0; tick();
    wa = $urandom; wb = ~wa;
    o_ready = 1'b1; i_cs_word = wa; i_valid = 1'b1;
    for (int k = 0; k < 388; k++) begin
      tick();
      i_left = $urandom; i_right = $urandom;
      if (k == 20) i_cs_word = wb;
      fr = (k / 2) % 192;
      w  = (k < 384) ? wa : wb;
      if (k % 2 == 0) begin
        checks++;
        if ({o_frame_index, o_control} !== {8'(fr), (fr < 32) ? w[fr] : 1'b0}) begin
          failures++;
          $display("FAIL cs_change k=%0d got idx=%0d ctl=%b exp idx=%0d ctl=%b", k,
                   o_frame_index, o_control, fr, (fr < 32) ? w[fr] : 1'b0);
        end
      end
    end
    i_valid = 1'b0;
    for (int c = 0; c < 8 && o_valid; c++) tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      o_ready = ($urandom_range(0, 3) != 0);
      i_left = $urandom; i_right = $urandom;
      if ($urandom_range(0, 63) == 0) i_cs_word = $urandom;
      tick();
    end
    i_valid = 1'b0; o_ready = 1'b1;
    for (int c = 0; c < 8 && o_valid; c++) tick();
    tick();
    checks++;
    if (o_valid !== 1'b0 || sq.size() != 0) begin
      failures++;
      $display("FAIL random_drain got v=%b pending=%0d exp 0 0", o_valid, sq.size());
    end
  endtask

  initial begin
    reset = 1'b1; i_valid = 1'b0; o_ready = 1'b1;
    i_left = '0; i_right = '0; i_cs_word = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_single_pair();
    test_cs_block();
    test_backpressure();
    test_width16();
    test_reset_mid();
    test_cs_change();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
